counter_job_scheduler: RTL and testbench
========================================

COUNTER_JOB_SCHEDULER -- requirements
Module: counter_job_scheduler

Interface
REQ-001 SHALL have parameter: W, 4, width of count/config values.
REQ-002 SHALL have port: clkin  in  1  single clock, all state changes on rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: req0/req1  in  1  job request per channel, held high until ack.
REQ-005 SHALL have ports: init0/init1, step0/step1, target0/target1  in  W  job config per channel.
REQ-006 SHALL have ports: dir0/dir1  in  1  0 = count up, 1 = count down.
REQ-007 SHALL have port: abort  in  1  synchronous cancel of the running job.
REQ-008 SHALL have ports: ack0/ack1  out  1  one-cycle job-accepted pulse.
REQ-009 SHALL have ports: done0/done1  out  1  one-cycle job-complete pulse.
REQ-010 SHALL have port: busy  out  1  high whenever state != IDLE.
REQ-011 SHALL have port: owner  out  1  channel being served; holds last value when idle.
REQ-012 SHALL have port: count_val  out  W  current counter value.
REQ-013 SHALL have port: status  out  2  last job result: 00 none, 01 HIT, 10 WRAP, 11 ABORT.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, RUN, FINISH.
REQ-015 IDLE: if any req high at edge, SHALL grant, set owner, capture that channel's init/step/target/dir, assert its ack for the following cycle, go LOAD.
REQ-016 Both req high in IDLE: grant SHALL go to channel != last_owner (round-robin); single req granted directly.
REQ-017 Config inputs SHALL be sampled only at the grant edge; later changes ignored until next grant.
REQ-018 req SHALL be sampled only in IDLE; requester deasserts req in the ack cycle, a req still high on return to IDLE is a new job.
REQ-019 LOAD: count_val <= init; init==target -> FINISH, status HIT; else step==0 -> FINISH, status ABORT; else -> RUN.
REQ-020 RUN: each edge next = count_val + step (dir=0) or - step (dir=1), computed W+1 bits wide.
REQ-021 RUN: carry-out (up) or borrow (down) SHALL go FINISH, status WRAP, count_val unchanged (no wrap-around written).
REQ-022 RUN: otherwise count_val <= next; next==target -> FINISH, status HIT; else stay RUN.
REQ-023 abort high at edge in LOAD or RUN SHALL go FINISH, status ABORT, count_val held; abort wins over HIT/WRAP same edge; ignored in IDLE/FINISH.
REQ-024 FINISH: done of owner channel SHALL be high for exactly this one cycle; next edge -> IDLE, last_owner <= owner.
REQ-025 status SHALL update on entry to FINISH and hold until next FINISH entry.
REQ-026 ack0/ack1 and done0/done1 SHALL be mutually exclusive per cycle and never high outside LOAD/FINISH respectively.
REQ-027 Latency: req sampled at edge E -> ack in cycle after E; count_val=init after E+1; first step after E+2; done in cycle after the edge that hits/wraps/aborts.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, count_val 0, ack/done 0, busy 0, status 00, owner 0, last_owner 1.
REQ-029 Reset mid-job SHALL discard the job with no done pulse; after release first tie grants channel 0.

Verification
REQ-030 ch0 init=2 step=3 target=11 dir=0 -> ack0 1 cycle, count 2,5,8,11, done0 in cycle count=11, status 01.
REQ-031 ch1 init=1 step=4 target=2 dir=0 -> count 1,5,9,13, then WRAP: status 10, count_val stays 13, done1.
REQ-032 ch0 init=5 step=3 target=0 dir=1 -> count 5,2, borrow -> status 10, count 2; init=7 target=7 -> done after LOAD, status 01.
REQ-033 req0 and req1 high together after reset -> ch0 served first, then ch1; repeat with last_owner=0 -> ch1 first.
REQ-034 abort asserted on 2nd RUN cycle -> FINISH, status 11, count held; step=0 init!=target -> status 11 after LOAD.
REQ-035 rst_n pulsed low mid-RUN -> all outputs reset asynchronously, no done pulse, busy 0.

Source files
------------

// File: rtl/counter_job_scheduler.sv
// Two-channel counting job scheduler.
// Grants one channel at a time (round-robin on ties), loads that channel's
// configuration, and counts from init toward target by +/-step. A job ends
// on hitting target (HIT), on carry/borrow out of W bits (WRAP), or on
// abort / zero step (ABORT), with a one-cycle done pulse to the owner.
module counter_job_scheduler #(
    parameter int W = 4
) (
    input  logic         clkin,
    input  logic         rst_n,
    input  logic         req0,
    input  logic         req1,
    input  logic [W-1:0] init0,
    input  logic [W-1:0] init1,
    input  logic [W-1:0] step0,
    input  logic [W-1:0] step1,
    input  logic [W-1:0] target0,
    input  logic [W-1:0] target1,
    input  logic         dir0,
    input  logic         dir1,
    input  logic         abort,
    output logic         ack0,
    output logic         ack1,
    output logic         done0,
    output logic         done1,
    output logic         busy,
    output logic         owner,
    output logic [W-1:0] count_val,
    output logic [1:0]   status
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, FINISH} state_t;
    typedef enum logic [1:0] {
        ST_NONE  = 2'b00,
        ST_HIT   = 2'b01,
        ST_WRAP  = 2'b10,
        ST_ABORT = 2'b11
    } status_t;

    state_t       state;
    status_t      status_q;
    logic         last_owner;

    // Job configuration captured at the grant edge only.
    logic [W-1:0] init_q;
    logic [W-1:0] step_q;
    logic [W-1:0] target_q;
    logic         dir_q;

    logic         grant_ch;
    logic [W:0]   next_wide;
    logic         fin;
    status_t      fin_status;

    // Tie goes to the channel that was not served last; a lone request wins outright.
    assign grant_ch = (req0 && req1) ? ~last_owner : req1;

    // One extra bit so that both carry (up) and borrow (down) land in bit W.
    assign next_wide = dir_q ? ({1'b0, count_val} - {1'b0, step_q})
                             : ({1'b0, count_val} + {1'b0, step_q});

    assign busy   = (state != IDLE);
    assign status = status_q;

    // Decide whether this edge ends the job, and with which result; abort has priority.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        fin        = 1'b0;
        fin_status = ST_NONE;
        unique case (state)
            LOAD: begin
                if (abort) begin
                    fin = 1'b1; fin_status = ST_ABORT;
                end else if (init_q == target_q) begin
                    fin = 1'b1; fin_status = ST_HIT;
                end else if (step_q == '0) begin
                    fin = 1'b1; fin_status = ST_ABORT;
                end
            end
            RUN: begin
                if (abort) begin
                    fin = 1'b1; fin_status = ST_ABORT;
                end else if (next_wide[W]) begin
                    fin = 1'b1; fin_status = ST_WRAP;
                end else if (next_wide[W-1:0] == target_q) begin
                    fin = 1'b1; fin_status = ST_HIT;
                end
            end
            default: ;
        endcase
    end

    // Scheduler FSM with registered ack/done pulses, counter and result status.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every register, configuration included, has a defined reset value;
            // there is no memory array here that would need to be left unreset.
            state      <= IDLE;
            status_q   <= ST_NONE;
            count_val  <= '0;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            init_q     <= '0;
            step_q     <= '0;
            target_q   <= '0;
            dir_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner    <= grant_ch;
                        init_q   <= grant_ch ? init1   : init0;
                        step_q   <= grant_ch ? step1   : step0;
                        target_q <= grant_ch ? target1 : target0;
                        dir_q    <= grant_ch ? dir1    : dir0;
                        ack0     <= ~grant_ch;
                        ack1     <= grant_ch;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (!abort) count_val <= init_q;
                    state <= fin ? FINISH : RUN;
                end
                RUN: begin
                    if (!abort && !next_wide[W]) count_val <= next_wide[W-1:0];
                    if (fin) state <= FINISH;
                end
                FINISH: begin
                    last_owner <= owner;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (fin) begin
                status_q <= fin_status;
                done0    <= ~owner;
                done1    <= owner;
            end
        end
    end

endmodule

// File: tb/tb_counter_job_scheduler.sv
// Self-checking bench for counter_job_scheduler: a job-level reference model
// compared on every falling edge, plus hand-computed per-job expectations.
module tb_counter_job_scheduler;

    localparam int W = 4;

    logic         clkin = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0] init0 = '0, init1 = '0, step0 = '0, step1 = '0;
    logic [W-1:0] target0 = '0, target1 = '0;
    logic         dir0 = 1'b0, dir1 = 1'b0;
    logic         abort = 1'b0;
    logic         ack0, ack1, done0, done1, busy, owner;
    logic [W-1:0] count_val;
    logic [1:0]   status;

    counter_job_scheduler #(.W(W)) dut (
        .clkin(clkin), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .init0(init0), .init1(init1),
        .step0(step0), .step1(step1),
        .target0(target0), .target1(target1),
        .dir0(dir0), .dir1(dir1),
        .abort(abort),
        .ack0(ack0), .ack1(ack1),
        .done0(done0), .done1(done1),
        .busy(busy), .owner(owner),
        .count_val(count_val), .status(status)
    );

    always #5 clkin = ~clkin;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (job phases, integer arithmetic) ----------------
    localparam int P_IDLE = 0, P_ACK = 1, P_COUNT = 2, P_DONE = 3;
    int ph, m_owner, m_last, m_cnt, m_status;
    int m_init, m_step, m_target, m_dir;
    int m_nxt, m_grant;

    always_comb begin
        m_nxt   = (m_dir != 0) ? m_cnt - m_step : m_cnt + m_step;
        m_grant = (req0 && req1) ? 1 - m_last : (req1 ? 1 : 0);
    end

    always @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            ph <= P_IDLE; m_owner <= 0; m_last <= 1; m_cnt <= 0; m_status <= 0;
            m_init <= 0; m_step <= 0; m_target <= 0; m_dir <= 0;
        end else begin
            case (ph)
                P_IDLE: if (req0 || req1) begin
                    ph       <= P_ACK;
                    m_owner  <= m_grant;
                    m_init   <= int'(m_grant == 1 ? init1 : init0);
                    m_step   <= int'(m_grant == 1 ? step1 : step0);
                    m_target <= int'(m_grant == 1 ? target1 : target0);
                    m_dir    <= int'(m_grant == 1 ? dir1 : dir0);
                end
                P_ACK: begin
                    if (abort) begin ph <= P_DONE; m_status <= 3; end
                    else begin
                        m_cnt <= m_init;
                        if (m_init == m_target)  begin ph <= P_DONE; m_status <= 1; end
                        else if (m_step == 0)    begin ph <= P_DONE; m_status <= 3; end
                        else                      ph <= P_COUNT;
                    end
                end
                P_COUNT: begin
                    if (abort)                          begin ph <= P_DONE; m_status <= 3; end
                    else if (m_nxt < 0 || m_nxt >= 16)  begin ph <= P_DONE; m_status <= 2; end
                    else begin
                        m_cnt <= m_nxt;
                        if (m_nxt == m_target) begin ph <= P_DONE; m_status <= 1; end
                    end
                end
                default: begin ph <= P_IDLE; m_last <= m_owner; end
            endcase
        end
    end

    // Compare every output against the model away from the active edge.
    always @(negedge clkin) begin
        check("cmp_ack0",  ack0,  ph == P_ACK && m_owner == 0);
        check("cmp_ack1",  ack1,  ph == P_ACK && m_owner == 1);
        check("cmp_done0", done0, ph == P_DONE && m_owner == 0);
        check("cmp_done1", done1, ph == P_DONE && m_owner == 1);
        check("cmp_busy",  busy,  ph != P_IDLE);
        check("cmp_owner", owner, m_owner);
        check("cmp_count", count_val, m_cnt);
        check("cmp_status", status, m_status);
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_cfg(input int ch, input int ini, input int stp, input int tgt, input int d);
        if (ch == 0) begin init0 = ini[W-1:0]; step0 = stp[W-1:0]; target0 = tgt[W-1:0]; dir0 = d[0]; end
        else         begin init1 = ini[W-1:0]; step1 = stp[W-1:0]; target1 = tgt[W-1:0]; dir1 = d[0]; end
    endtask

    task automatic drive_req(input int ch, input bit v);
        if (ch == 0) req0 = v; else req1 = v;
    endtask

    task automatic await_ack(input int ch);
        bit seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clkin);
            if (ch == 0 ? ack0 : ack1) seen = 1'b1;
        end
        check($sformatf("ack%0d_seen", ch), seen, 1);
        drive_req(ch, 1'b0);
    endtask

    task automatic await_done(input int ch, input int abort_at, output int k_done);
        k_done = -1;
        for (int k = 1; k <= 40 && k_done < 0; k++) begin
            @(negedge clkin);
            if (ch == 0 ? done0 : done1) k_done = k;
            else abort = (k == abort_at);
        end
        abort = 1'b0;
        check($sformatf("done%0d_seen", ch), k_done >= 0, 1);
    endtask

    task automatic run_job(input string name, input int ch, input int ini, input int stp,
                           input int tgt, input int d, input int abort_at,
                           input int exp_cnt, input int exp_st, input int exp_k);
        int k;
        set_cfg(ch, ini, stp, tgt, d);
        drive_req(ch, 1'b1);
        await_ack(ch);
        // Config changes after the grant must not affect the running job.
        set_cfg(ch, 15 - ini, 15 - stp, 15 - tgt, 1 - d);
        await_done(ch, abort_at, k);
        check({name, "_cycles"}, k, exp_k);
        check({name, "_count"}, count_val, exp_cnt);
        check({name, "_status"}, status, exp_st);
        @(negedge clkin);
        check({name, "_idle_after"}, busy, 0);
    endtask

    task automatic tie(input string name, input int exp_first);
        int first = -1;
        int k;
        set_cfg(0, 0, 5, 10, 0);
        set_cfg(1, 8, 2, 4, 1);
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 8 && first < 0; i++) begin
            @(negedge clkin);
            if (ack0) first = 0;
            else if (ack1) first = 1;
        end
        check({name, "_first"}, first, exp_first);
        if (first < 0) first = exp_first;
        drive_req(first, 1'b0);
        await_done(first, -1, k);
        check({name, "_first_count"}, count_val, first == 0 ? 10 : 4);
        await_ack(1 - first);
        await_done(1 - first, -1, k);
        check({name, "_second_count"}, count_val, first == 0 ? 4 : 10);
        @(negedge clkin);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clkin);
        check("rst_busy", busy, 0);
        check("rst_count", count_val, 0);
        check("rst_status", status, 0);
        check("rst_ack", {ack0, ack1, done0, done1}, 0);
        rst_n = 1'b1;
        @(negedge clkin);

        run_job("up_hit",      0, 2, 3, 11, 0, -1, 11, 1, 4);
        run_job("up_wrap",     1, 1, 4,  2, 0, -1, 13, 2, 5);
        run_job("down_borrow", 0, 5, 3,  0, 1, -1,  2, 2, 3);
        run_job("init_eq_tgt", 0, 7, 1,  7, 0, -1,  7, 1, 1);
        run_job("abort_run2",  0, 0, 1,  9, 0,  2,  1, 3, 3);
        run_job("zero_step",   1, 3, 0,  5, 0, -1,  3, 3, 1);

        tie("tie_a", 0);
        run_job("single_ch0",  0, 4, 4, 12, 0, -1, 12, 1, 3);
        tie("tie_b", 1);

        // Reset in the middle of a long counting job.
        set_cfg(1, 0, 1, 15, 0);
        req1 = 1'b1;
        await_ack(1);
        repeat (3) @(negedge clkin);
        check("midrun_count", count_val, 2);
        #7 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_count", count_val, 0);
        check("arst_status", status, 0);
        check("arst_owner", owner, 0);
        check("arst_pulses", {ack0, ack1, done0, done1}, 0);
        repeat (2) @(negedge clkin);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clkin);
            check("arst_no_done", done1, 0);
        end
        tie("tie_after_rst", 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
